top: RTL and testbench

// - Top-level two-digit hexadecimal display driver for an 8-bit value.
// - Registers Value[7:4] and Value[3:0] as two 7-segment patterns plus a decimal point (DP).
// - SevenSegDig1 is the high nibble; SevenSegDig2 is the low nibble.
// - Sits between the datapath and the board's two 7-segment digit drivers.

---
 rtl/seg7_pkg.sv | 17 +
 rtl/hex_to_7seg.sv | 13 +
 rtl/top.sv | 58 +++++
 tb/tb_top.sv | 132 +++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: the off pattern, the hex decode table and a lookup helper.
// Patterns are active-high {dp,g,f,e,d,c,b,a}, bit0 = a.
package seg7_pkg;

  localparam logic [7:0] SEG_OFF = 8'h00;

  localparam logic [7:0] SEG_HEX [0:15] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
    8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
  };

  // The table covers all 16 codes, so the lookup never yields X for a known nibble.
  function automatic logic [7:0] nibble_to_seg(input logic [3:0] nibble);
    return SEG_HEX[nibble];
  endfunction

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational nibble to 7-segment decoder; DP is always off.
module hex_to_7seg
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [7:0] seg_o
);

  always_comb begin
    seg_o = nibble_to_seg(nibble_i);
  end

endmodule

// File: rtl/top.sv
// Two-digit hex display driver: decodes Value into registered high/low 7-segment words
// with optional leading-zero blanking on the high digit and optional output inversion.
module top
  import seg7_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW  = 1'b0,
  parameter bit BLANK_LEAD_ZERO = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] Value,
  output logic [7:0] SevenSegDig1,
  output logic [7:0] SevenSegDig2
);

  localparam logic [7:0] OffWord = SEG_ACTIVE_LOW ? ~SEG_OFF : SEG_OFF;

  logic [7:0] seg_hi, seg_lo;
  logic [7:0] dig1_d, dig1_q;
  logic [7:0] dig2_d, dig2_q;

  hex_to_7seg u_dec_hi (
    .nibble_i (Value[7:4]),
    .seg_o    (seg_hi)
  );

  hex_to_7seg u_dec_lo (
    .nibble_i (Value[3:0]),
    .seg_o    (seg_lo)
  );

  // Inversion is the last step so a blanked digit still reads as "off" on common-anode parts.
  always_comb begin
    dig1_d = seg_hi;
    dig2_d = seg_lo;
    if (BLANK_LEAD_ZERO && (Value[7:4] == 4'h0)) begin
      dig1_d = SEG_OFF;
    end
    if (SEG_ACTIVE_LOW) begin
      dig1_d = ~dig1_d;
      dig2_d = ~dig2_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dig1_q <= OffWord;
      dig2_q <= OffWord;
    end else begin
      dig1_q <= dig1_d;
      dig2_q <= dig2_d;
    end
  end

  assign SevenSegDig1 = dig1_q;
  assign SevenSegDig2 = dig2_q;

endmodule

// File: tb/tb_top.sv
// Directed bench for top: default, active-low and leading-zero-blanking instances
// share one clock, reset and Value stimulus.
module tb_top;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] value;
  logic [7:0] d1_def, d2_def, d1_al, d2_al, d1_bl, d2_bl;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] tab [0:15];

  always #5 clk = ~clk;

  top u_dut_def (
    .clk          (clk),
    .rst_n        (rst_n),
    .Value        (value),
    .SevenSegDig1 (d1_def),
    .SevenSegDig2 (d2_def)
  );

  top #(.SEG_ACTIVE_LOW(1'b1), .BLANK_LEAD_ZERO(1'b0)) u_dut_al (
    .clk          (clk),
    .rst_n        (rst_n),
    .Value        (value),
    .SevenSegDig1 (d1_al),
    .SevenSegDig2 (d2_al)
  );

  top #(.SEG_ACTIVE_LOW(1'b0), .BLANK_LEAD_ZERO(1'b1)) u_dut_bl (
    .clk          (clk),
    .rst_n        (rst_n),
    .Value        (value),
    .SevenSegDig1 (d1_bl),
    .SevenSegDig2 (d2_bl)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h, expected %02h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tab[0]  = 8'h3F; tab[1]  = 8'h06; tab[2]  = 8'h5B; tab[3]  = 8'h4F;
    tab[4]  = 8'h66; tab[5]  = 8'h6D; tab[6]  = 8'h7D; tab[7]  = 8'h07;
    tab[8]  = 8'h7F; tab[9]  = 8'h6F; tab[10] = 8'h77; tab[11] = 8'h7C;
    tab[12] = 8'h39; tab[13] = 8'h5E; tab[14] = 8'h79; tab[15] = 8'h71;

    rst_n = 1'b0;
    value = 8'h13;
    step();
    step();
    check("rst_def_d1", d1_def, 8'h00);
    check("rst_def_d2", d2_def, 8'h00);
    check("rst_al_d1",  d1_al,  8'hFF);
    check("rst_al_d2",  d2_al,  8'hFF);
    check("rst_bl_d1",  d1_bl,  8'h00);
    check("rst_bl_d2",  d2_bl,  8'h00);

    rst_n = 1'b1;
    step();
    check("basic_d1",    d1_def, 8'b0000_0110);
    check("basic_d2",    d2_def, 8'b0100_1111);
    check("basic_al_d1", d1_al,  8'hF9);
    check("basic_al_d2", d2_al,  8'hB0);
    check("basic_bl_d1", d1_bl,  8'h06);
    check("basic_bl_d2", d2_bl,  8'h4F);

    // Value changes between edges; outputs must hold until the next rising edge.
    value = 8'hA5;
    #3;
    check("lat_hold_d1", d1_def, 8'h06);
    check("lat_hold_d2", d2_def, 8'h4F);
    step();
    check("lat_upd_d1", d1_def, 8'h77);
    check("lat_upd_d2", d2_def, 8'h6D);

    value = 8'h07;
    step();
    check("blank07_d1",  d1_bl,  8'h00);
    check("blank07_d2",  d2_bl,  8'h07);
    check("noblank_d1",  d1_def, 8'h3F);
    check("al07_d1",     d1_al,  8'hC0);
    check("al07_d2",     d2_al,  8'hF8);

    value = 8'h00;
    step();
    check("blank00_d1", d1_bl, 8'h00);
    check("blank00_d2", d2_bl, 8'h3F);

    value = 8'hF0;
    step();
    check("f0_d1", d1_def, 8'h71);
    check("f0_d2", d2_def, 8'h3F);
    check("f0_bl_d1", d1_bl, 8'h71);

    // Full sweep with a one-cycle reset pulse in the middle.
    for (int i = 0; i < 256; i++) begin
      value = 8'(i);
      if (i == 8'h80) begin
        rst_n = 1'b0;
        step();
        check("mid_rst_d1",    d1_def, 8'h00);
        check("mid_rst_d2",    d2_def, 8'h00);
        check("mid_rst_al_d1", d1_al,  8'hFF);
        rst_n = 1'b1;
      end
      step();
      check("sweep_d1",    d1_def, tab[i / 16]);
      check("sweep_d2",    d2_def, tab[i % 16]);
      check("sweep_al_d1", d1_al,  ~tab[i / 16]);
      check("sweep_al_d2", d2_al,  ~tab[i % 16]);
      check("sweep_bl_d1", d1_bl,  (i < 16) ? 8'h00 : tab[i / 16]);
      check("sweep_bl_d2", d2_bl,  tab[i % 16]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
